// File: rtl/ypc_pkg.sv
// ypc_pkg -- shared types and constants for the YPC instruction-fetch stage.
//
// Contents:
//   YPC_XLEN      datapath width (PC, address, instruction)
//   YPC_RESET_PC  default architectural PC after reset
//   YPC_NOP       encoding of the canonical NOP (addi x0, x0, 0)
//   fetch_state_e fetch FSM states
package ypc_pkg;

    localparam int          YPC_XLEN     = 32;
    localparam logic [31:0] YPC_RESET_PC = 32'h8000_0000;
    localparam logic [31:0] YPC_NOP      = 32'h0000_0013;

    // IDLE: one cycle after reset release; REQ: request presented to memory;
    // WAIT: request accepted, response pending; HOLD: instruction offered to decode.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/ifu_out_buf.sv
// ifu_out_buf -- one-entry valid/ready holding register for {inst, pc}
// between fetch and decode.
//
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   load                capture load_inst/load_pc and raise out_valid
//   load_inst, load_pc  entry to capture
//   flush               drop the held entry without a handshake (wins over all)
//   out_valid/out_ready decode-side handshake
//   out_inst, out_pc    held entry; stable while out_valid and not consumed
module ifu_out_buf
    import ypc_pkg::*;
#(
    parameter int XLEN = YPC_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_inst,
    input  logic [XLEN-1:0] load_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] inst_q,  inst_d;
    logic [XLEN-1:0] pc_q,    pc_d;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            inst_d  = load_inst;
            pc_d    = load_pc;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            inst_q  <= XLEN'(YPC_NOP);
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
        end
    end

    assign out_valid = valid_q;
    assign out_inst  = inst_q;
    assign out_pc    = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction-fetch stage of the YPC core.
//
// Owns the architectural PC, issues one word-aligned fetch at a time over a
// valid/ready request channel, and hands {inst, pc} to decode through
// ifu_out_buf. A one-cycle redirect from execute overrides every other event.
//
// Ports:
//   clk, rst                       clock; asynchronous active-low reset
//   mem_req_valid/ready/addr       fetch request (addr always word aligned)
//   mem_resp_valid/data            fetch response (at most one per request)
//   out_valid/ready, out_inst/pc   instruction to decode
//   redirect_valid, redirect_pc    redirect pulse and target (bits [1:0] ignored)
module ifu_fetch
    import ypc_pkg::*;
#(
    parameter int            XLEN     = YPC_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = YPC_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;      // a stale response is still owed by memory
    logic            req_valid_q, req_valid_d;

    logic            req_fire;
    logic            buf_load;
    logic            buf_flush;
    logic [XLEN-1:0] redirect_target;
    logic            redirect_lsb_unused;

    assign req_fire            = req_valid_q && mem_req_ready;
    assign redirect_target     = {redirect_pc[XLEN-1:2], 2'b00};
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        buf_load  = 1'b0;
        buf_flush = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect_valid) pc_d = redirect_target;
            end

            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    // If the old request was just accepted its response must
                    // still be absorbed before fetching from the new target.
                    if (req_fire) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (req_fire) begin
                    state_d = WAIT;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    if (mem_resp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (mem_resp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        buf_load = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    // Flush wins over a same-cycle out_ready: the stale
                    // instruction must not be counted as consumed.
                    buf_flush = 1'b1;
                    pc_d      = redirect_target;
                    state_d   = REQ;
                end else if (out_valid && out_ready) begin
                    pc_d    = pc_q + XLEN'(4);   // wraps modulo 2^XLEN
                    state_d = REQ;
                end
            end

            default: state_d = IDLE;
        endcase

        // Registered request valid: asserted exactly while the FSM sits in REQ.
        req_valid_d = (state_d == REQ);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_q      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_q      <= drop_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = pc_q;

    ifu_out_buf #(
        .XLEN (XLEN)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .load_inst (mem_resp_data),
        .load_pc   (pc_q),
        .flush     (buf_flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc)
    );

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch -- self-checking bench for ifu_fetch.
//
// A reference model tracks which instruction address decode should consume
// next (sequential +4, or the aligned redirect target). The stimulus side
// keeps the expected {pc, inst} in a queue; a monitor pops and compares on
// every decode handshake. A memory responder returns a fixed function of the
// address after a programmable latency. Directed phases cover reset, latency,
// back-pressure, redirects in HOLD/WAIT, PC wrap and async reset; a random
// phase follows.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_pops   = 0;

    exp_t        exp_q[$];
    logic [31:0] model_pc;

    int          lat = 1;
    logic        inject = 1'b0;
    logic [31:0] inject_data = '0;
    logic        pend_valid;
    logic [31:0] pend_addr;
    int          pend_cnt;

    logic        deadbeef_watch = 1'b0;
    logic        deadbeef_seen  = 1'b0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Instruction memory contents.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        if (a == 32'h8000_0008) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] b32(input logic x);
        return {31'd0, x};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_next(input logic [31:0] pc);
        exp_t e;
        e.pc   = pc;
        e.inst = mem_word(pc);
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc = RESET_PC;
        expect_next(model_pc);
    endtask

    // Drive-phase point: 1ns after the rising edge. Keeps one expected entry primed.
    task automatic tick();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            model_pc = model_pc + 32'd4;
            expect_next(model_pc);
        end
    endtask

    task automatic set_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        model_pc = {tgt[31:2], 2'b00};
        expect_next(model_pc);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!mem_req_valid && n < 60) begin
            tick();
            n++;
        end
        check({name, "_req_seen"}, b32(mem_req_valid), 32'd1);
    endtask

    task automatic wait_out(input string name);
        int n = 0;
        while (!out_valid && n < 60) begin
            tick();
            n++;
        end
        check({name, "_out_seen"}, b32(out_valid), 32'd1);
    endtask

    // Memory responder: drives at 2ns after the edge, observes at the falling edge.
    initial begin : responder
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        pend_valid     = 1'b0;
        pend_addr      = '0;
        pend_cnt       = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst) pend_valid = 1'b0;
            if (inject) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = inject_data;
            end else if (pend_valid && pend_cnt == 0) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_word(pend_addr);
            end else begin
                mem_resp_valid = 1'b0;
                mem_resp_data  = $urandom;
            end
            @(negedge clk);
            if (!rst) begin
                pend_valid = 1'b0;
            end else begin
                if (mem_resp_valid && !inject) pend_valid = 1'b0;
                else if (pend_valid && pend_cnt > 0) pend_cnt--;
                if (mem_req_valid && mem_req_ready) begin
                    check("one_outstanding", b32(pend_valid), 32'd0);
                    pend_valid = 1'b1;
                    pend_addr  = mem_req_addr;
                    pend_cnt   = lat - 1;
                end
            end
        end
    end

    // Scoreboard monitor: a decode handshake happens at the next rising edge.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL sb_empty: consumed pc %h with no expected entry", out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_pc", out_pc, e.pc);
                check("sb_inst", out_inst, e.inst);
                n_pops++;
            end
        end
        if (rst && mem_req_valid)
            check("req_addr_aligned", {30'd0, mem_req_addr[1:0]}, 32'd0);
        if (deadbeef_watch && out_valid && out_inst == 32'hDEAD_BEEF)
            deadbeef_seen = 1'b1;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int pops_before;
        model_reset();

        // Reset values.
        repeat (2) tick();
        check("rst_req_valid", b32(mem_req_valid), 32'd0);
        check("rst_req_addr", mem_req_addr, RESET_PC);
        check("rst_out_valid", b32(out_valid), 32'd0);
        check("rst_out_inst", out_inst, NOP);
        check("rst_out_pc", out_pc, 32'd0);

        // 1: first fetch latency.
        mem_req_ready = 1'b1;
        out_ready     = 1'b1;
        lat           = 1;
        rst           = 1'b1;
        tick();
        check("t1_req_valid", b32(mem_req_valid), 32'd1);
        check("t1_req_addr", mem_req_addr, 32'h8000_0000);
        tick();
        check("t1_wait_no_req", b32(mem_req_valid), 32'd0);
        tick();
        check("t1_out_valid", b32(out_valid), 32'd1);
        check("t1_out_pc", out_pc, 32'h8000_0000);
        check("t1_out_inst", out_inst, 32'h0000_0413);
        tick();
        check("t1_next_req_valid", b32(mem_req_valid), 32'd1);
        check("t1_next_req_addr", mem_req_addr, 32'h8000_0004);
        check("t1_out_cleared", b32(out_valid), 32'd0);

        // 2: back-pressure in HOLD.
        out_ready = 1'b0;
        wait_out("t2");
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", b32(out_valid), 32'd1);
            check("t2_hold_pc", out_pc, 32'h8000_0004);
            check("t2_hold_inst", out_inst, mem_word(32'h8000_0004));
            check("t2_no_req", b32(mem_req_valid), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        lat       = 3;
        tick();
        check("t2_req_valid", b32(mem_req_valid), 32'd1);
        check("t2_req_addr", mem_req_addr, 32'h8000_0008);
        tick();
        check("t2_single_req", b32(mem_req_valid), 32'd0);

        // 4: redirect while the 0x80000008 fetch is outstanding.
        deadbeef_watch = 1'b1;
        set_redirect(32'h8000_0200);
        tick();
        redirect_valid = 1'b0;
        lat            = 1;
        wait_req("t4");
        check("t4_req_addr", mem_req_addr, 32'h8000_0200);
        out_ready = 1'b0;

        // 3: redirect in HOLD with out_ready in the same cycle.
        wait_out("t3");
        check("t3_held_pc", out_pc, 32'h8000_0200);
        deadbeef_watch = 1'b0;
        check("t4_deadbeef_seen", b32(deadbeef_seen), 32'd0);
        out_ready   = 1'b1;
        pops_before = n_pops;
        set_redirect(32'h8000_0103);
        tick();
        redirect_valid = 1'b0;
        check("t3_out_dropped", b32(out_valid), 32'd0);
        check("t3_no_handshake", n_pops, pops_before);
        wait_req("t3");
        check("t3_req_addr", mem_req_addr, 32'h8000_0100);

        // 5: wrap-around; redirect lands in WAIT together with the response.
        tick();
        set_redirect(32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        wait_req("t5a");
        check("t5_req_top", mem_req_addr, 32'hFFFF_FFFC);
        tick();
        wait_req("t5b");
        check("t5_req_wrap", mem_req_addr, 32'h0000_0000);

        // 6: async reset in the middle of WAIT.
        lat = 3;
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("t6_req_valid", b32(mem_req_valid), 32'd0);
        check("t6_out_valid", b32(out_valid), 32'd0);
        check("t6_pc", mem_req_addr, RESET_PC);
        check("t6_out_inst", out_inst, NOP);
        model_reset();
        tick();
        inject      = 1'b1;
        inject_data = 32'hBAD0_0013;
        repeat (2) tick();
        inject = 1'b0;
        tick();
        check("t6_resp_ignored_out", b32(out_valid), 32'd0);
        check("t6_resp_ignored_req", b32(mem_req_valid), 32'd0);
        lat = 1;
        rst = 1'b1;
        tick();
        check("t6_restart_addr", mem_req_addr, RESET_PC);

        // Random phase.
        pops_before = n_pops;
        for (int i = 0; i < 1500; i++) begin
            mem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            lat           = int'($urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) set_redirect($urandom);
            else                            redirect_valid = 1'b0;
            tick();
        end
        redirect_valid = 1'b0;
        mem_req_ready  = 1'b1;
        out_ready      = 1'b1;
        repeat (20) tick();
        check("rand_progress", b32(n_pops - pops_before > 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage (IDU) in the YPC core. It owns the architectural PC and issues one word-aligned fetch at a time to instruction memory over a valid/ready request and response channel. It presents {inst, pc} to decode through a one-entry valid/ready output buffer. It also accepts a redirect (jump/branch target) from the execute stage.

Parameters:
RESET_PC, 32'h80000000, PC value loaded at reset.
XLEN, 32, width of PC, address and instruction.

Ports:
clk  input  1  core clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (asserted at 0)
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  XLEN  fetch address, always [1:0]=0
mem_resp_valid  input  1  fetch data returned (memory guarantees at most one per accepted request)
mem_resp_data  input  XLEN  instruction word
out_valid  output  1  {out_inst, out_pc} valid to IDU
out_ready  input  1  IDU accepts instruction
out_inst  output  XLEN  fetched instruction
out_pc  output  XLEN  address of out_inst
redirect_valid  input  1  one-cycle redirect pulse from EXU
redirect_pc  input  XLEN  redirect target; bits [1:0] ignored

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, pc=RESET_PC.
  - mem_req_valid=0, mem_req_addr=RESET_PC.
  - out_valid=0, out_inst=32'h00000013 (NOP), out_pc=0.
  - A drop flag is cleared.
- All outputs are registered. At most one request is outstanding at any time.
- States:
  - IDLE: go to REQ the next cycle unconditionally. This gives the first mem_req_valid one cycle after reset release.
  - REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_valid&mem_req_ready, go to WAIT.
  - WAIT: mem_req_valid=0. On mem_resp_valid:
    - If drop=1: discard the data, clear drop, go to REQ.
    - Else: load out_inst=mem_resp_data, out_pc=pc, out_valid=1, go to HOLD.
  - HOLD: out_valid=1, and out_inst/out_pc are held stable until out_valid&out_ready. On that handshake: pc<=pc+4, out_valid<=0, go to REQ.
- Latency (no stalls): request accepted in cycle N, response in N+1 at the earliest, out_valid in N+2. The next request is issued the cycle after the output handshake.
- PC arithmetic: modulo 2^32, so 32'hFFFFFFFC+4 = 0. No trap is raised.
- Redirect has priority over every other event in the same cycle. The target is T = {redirect_pc[31:2],2'b00}.
  - In IDLE or REQ without a same-cycle request handshake: pc<=T, mem_req_addr<=T, state REQ. The address may change while valid only in this case.
  - In REQ with a same-cycle request handshake, or in WAIT without a same-cycle response: pc<=T, drop<=1, state WAIT. The stale response is discarded, then the fetch goes to T.
  - In WAIT with a same-cycle response: the response is discarded, pc<=T, state REQ.
  - In HOLD: out_valid<=0 even if out_ready=1 in that cycle, so the stale instruction is not counted as consumed. pc<=T, state REQ.
- A response outside WAIT is a protocol error and is ignored.
- rst asserted mid-transaction returns everything to reset values immediately. No response is expected afterwards.

Decomposition:
- ypc_pkg holds:
  - the fetch-state enum (IDLE, REQ, WAIT, HOLD);
  - the RESET_PC default;
  - the NOP encoding 32'h00000013;
  - the XLEN constant.
- One sub-module, ifu_out_buf: a one-entry valid/ready holding register for {inst, pc} with a flush input. It is driven by redirect in HOLD.
- PC and FSM stay in ifu_fetch.

Test Plan:
1. Reset release, with mem_req_ready=1 and the response one cycle later carrying 32'h00000413:
   - mem_req_addr=32'h80000000 in cycle 1;
   - out_valid=1 with out_pc=32'h80000000 and out_inst=32'h00000413 in cycle 3;
   - next request to 32'h80000004.
2. Back-pressure: out_ready=0 for 5 cycles in HOLD.
   - out_valid, out_inst and out_pc stay stable.
   - No mem_req_valid is issued.
   - After out_ready=1, exactly one request goes to pc+4.
3. Redirect in HOLD: redirect_valid=1 with redirect_pc=32'h80000103 and out_ready=1 in the same cycle.
   - out_valid drops with no handshake counted.
   - The next request address is 32'h80000100.
4. Redirect in WAIT: a request to 32'h80000008 is outstanding; redirect to 32'h80000200; the response 32'hDEADBEEF arrives 3 cycles later.
   - DEADBEEF never appears on out_inst.
   - The next request is 32'h80000200.
5. Wrap-around: redirect to 32'hFFFFFFFC and consume that instruction.
   - The next mem_req_addr is 32'h00000000.
6. Asynchronous reset asserted mid-WAIT, between clock edges:
   - mem_req_valid=0, out_valid=0 and pc=32'h80000000 immediately, without waiting for a clock edge;
   - a response arriving during reset is ignored.
